// File: rtl/led_fade_ctrl.sv
// rtl/led_fade_ctrl.sv - PWM duty-cycle fader with period-aligned 1-LSB steps
//
// Purpose:
//   Accepts (target, rate) commands and ramps DutyCycle toward the target one
//   LSB per Rate PWM periods. Every DutyCycle change is taken on a period
//   boundary (tick), so the downstream PWM generator never sees a change in
//   the middle of a period.
//
// Ports:
//   SysClk      in   clock, rising edge
//   Reset       in   synchronous, active-high
//   CmdValid    in   host command valid
//   CmdReady    out  command accepted this cycle when CmdValid is also high
//   CmdTarget   in   [7:0] target duty
//   CmdRate     in   [7:0] PWM periods per step; 0 = jump on the next tick
//   DutyCycle   out  [7:0] duty value to the PWM generator
//   Busy        out  ramp in progress
//   Done        out  one-cycle pulse when DutyCycle reaches the target
//   BreatheReq  in   breathe request, sampled on accept (LED_BREATHE_EN only)
//
// Configuration:
//   LED_BREATHE_EN - adds BreatheReq and the BREATHE_UP/BREATHE_DOWN states,
//   which cycle DutyCycle between Target and 0 indefinitely.

module led_fade_ctrl #(
    parameter int PERIOD_CLKS = 256,
    parameter int CNT_W       = 8
) (
    input  logic       SysClk,
    input  logic       Reset,
    input  logic       CmdValid,
    output logic       CmdReady,
    input  logic [7:0] CmdTarget,
    input  logic [7:0] CmdRate,
    output logic [7:0] DutyCycle,
    output logic       Busy,
    output logic       Done
`ifdef LED_BREATHE_EN
    ,
    input  logic       BreatheReq
`endif
);

    localparam logic [2:0] IDLE         = 3'd0;
    localparam logic [2:0] RAMP_UP      = 3'd1;
    localparam logic [2:0] RAMP_DOWN    = 3'd2;
`ifdef LED_BREATHE_EN
    localparam logic [2:0] BREATHE_UP   = 3'd3;
    localparam logic [2:0] BREATHE_DOWN = 3'd4;
`endif

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD_CLKS - 1);

    logic [CNT_W-1:0] PerCnt;
    logic             tick;
    logic [2:0]       state;
    logic [7:0]       Target;
    logic [7:0]       Rate;
    logic [7:0]       RateCnt;

    logic             accept;
    logic             moving;
    logic             stepUp;
    logic [7:0]       dest;
    logic [7:0]       rateEff;
    logic             stepNow;
    logic [7:0]       nextDuty;

    // Free-running period counter; commands never disturb PWM phase.
    always_ff @(posedge SysClk) begin
        if (Reset || tick) begin
            PerCnt <= '0;
        end else begin
            PerCnt <= PerCnt + 1'b1;
        end
    end

    assign tick   = (PerCnt == LAST_CNT);
    assign accept = CmdValid & CmdReady;
    assign Busy   = (state != IDLE);

    always_comb begin
        moving = 1'b0;
        stepUp = 1'b0;
        dest   = Target;
        case (state)
            RAMP_UP:      begin moving = 1'b1; stepUp = 1'b1; end
            RAMP_DOWN:    begin moving = 1'b1; end
`ifdef LED_BREATHE_EN
            BREATHE_UP:   begin moving = 1'b1; stepUp = 1'b1; end
            BREATHE_DOWN: begin moving = 1'b1; dest = 8'd0; end
`endif
            default:      begin moving = 1'b0; end
        endcase

        // Rate 0 and 1 both step every tick; 9-bit compare avoids overflow.
        rateEff = (Rate == 8'd0) ? 8'd1 : Rate;
        stepNow = ({1'b0, RateCnt} + 9'd1) >= {1'b0, rateEff};

        // The state was chosen from the sign of (dest - DutyCycle), so a
        // single LSB step toward dest can never pass it or wrap.
        if (Rate == 8'd0) begin
            nextDuty = dest;
        end else if (stepUp) begin
            nextDuty = DutyCycle + 8'd1;
        end else begin
            nextDuty = DutyCycle - 8'd1;
        end
    end

    always_ff @(posedge SysClk) begin
        if (Reset) begin
            state     <= IDLE;
            CmdReady  <= 1'b1;
            DutyCycle <= 8'd0;
            Target    <= 8'd0;
            Rate      <= 8'd0;
            RateCnt   <= 8'd0;
            Done      <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (accept) begin
                Target  <= CmdTarget;
                Rate    <= CmdRate;
                RateCnt <= 8'd0;
`ifdef LED_BREATHE_EN
                if (BreatheReq && (CmdTarget != 8'd0)) begin
                    // Equal target heads straight into the down half.
                    state    <= (CmdTarget > DutyCycle) ? BREATHE_UP : BREATHE_DOWN;
                    CmdReady <= 1'b1;
                end else
`endif
                if (CmdTarget > DutyCycle) begin
                    state    <= RAMP_UP;
                    CmdReady <= 1'b0;
                end else if (CmdTarget < DutyCycle) begin
                    state    <= RAMP_DOWN;
                    CmdReady <= 1'b0;
                end else begin
                    state    <= IDLE;
                    CmdReady <= 1'b1;
                    Done     <= 1'b1;
                end
            end else if (moving && tick) begin
                if (stepNow) begin
                    RateCnt   <= 8'd0;
                    DutyCycle <= nextDuty;
                    if (nextDuty == dest) begin
                        case (state)
`ifdef LED_BREATHE_EN
                            BREATHE_UP:   state <= BREATHE_DOWN;
                            BREATHE_DOWN: state <= BREATHE_UP;
`endif
                            default: begin
                                state    <= IDLE;
                                CmdReady <= 1'b1;
                                Done     <= 1'b1;
                            end
                        endcase
                    end
                end else begin
                    RateCnt <= RateCnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_fade_ctrl.sv
// tb/tb_led_fade_ctrl.sv - directed self-checking bench for led_fade_ctrl

module tb_led_fade_ctrl;

    logic       SysClk = 1'b0;
    logic       Reset = 1'b1;
    logic       CmdValid = 1'b0;
    logic       CmdReady;
    logic [7:0] CmdTarget = 8'd0;
    logic [7:0] CmdRate = 8'd0;
    logic [7:0] DutyCycle;
    logic       Busy;
    logic       Done;
    logic       BreatheReq = 1'b0;

    int total = 0;
    int bad   = 0;
    int phase = 0;

    led_fade_ctrl #(.PERIOD_CLKS(4), .CNT_W(2)) dut (
        .SysClk    (SysClk),
        .Reset     (Reset),
        .CmdValid  (CmdValid),
        .CmdReady  (CmdReady),
        .CmdTarget (CmdTarget),
        .CmdRate   (CmdRate),
        .DutyCycle (DutyCycle),
        .Busy      (Busy),
        .Done      (Done)
`ifdef LED_BREATHE_EN
        ,
        .BreatheReq(BreatheReq)
`endif
    );

    always #5 SysClk = ~SysClk;

    task automatic step();
        @(posedge SysClk);
        #1;
        phase = (phase + 1) % 4;
    endtask

    task automatic apply_reset();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
        phase = 0;
    endtask

    task automatic align();
        while (phase != 0) step();
    endtask

    task automatic check_outputs(input string name, input int c, input logic [7:0] expDuty,
                                 input logic expBusy, input logic expReady, input logic expDone);
        total += 4;
        if (DutyCycle !== expDuty) begin
            bad++;
            $display("FAIL %s cycle %0d DutyCycle got %0d want %0d", name, c, DutyCycle, expDuty);
        end
        if (Busy !== expBusy) begin
            bad++;
            $display("FAIL %s cycle %0d Busy got %b want %b", name, c, Busy, expBusy);
        end
        if (CmdReady !== expReady) begin
            bad++;
            $display("FAIL %s cycle %0d CmdReady got %b want %b", name, c, CmdReady, expReady);
        end
        if (Done !== expDone) begin
            bad++;
            $display("FAIL %s cycle %0d Done got %b want %b", name, c, Done, expDone);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 10; i++) step();
        check_outputs("reset_idle", 10, 8'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_ramp_up();
        logic [7:0] ed;
        align();
        CmdValid = 1'b1; CmdTarget = 8'd3; CmdRate = 8'd1;
        for (int c = 1; c <= 14; c++) begin
            step();
            CmdValid = 1'b0;
            ed = (c >= 12) ? 8'd3 : (c >= 8) ? 8'd2 : (c >= 4) ? 8'd1 : 8'd0;
            check_outputs("ramp_up", c, ed, (c <= 11), (c >= 12), (c == 12));
        end
    endtask

    task automatic test_ramp_down_holdoff();
        logic [7:0] ed;
        align();
        CmdValid = 1'b1; CmdTarget = 8'd0; CmdRate = 8'd2;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (c == 1) begin
                CmdTarget = 8'd200; CmdRate = 8'd0;
            end
            if (c == 25) CmdValid = 1'b0;
            ed = (c >= 28) ? 8'd200 : (c >= 24) ? 8'd0 : (c >= 16) ? 8'd1 :
                 (c >= 8) ? 8'd2 : 8'd3;
            check_outputs("ramp_down_hold", c, ed, !(c == 24 || c >= 28),
                          (c == 24 || c >= 28), (c == 24 || c == 28));
        end
    endtask

    task automatic test_same_target();
        CmdValid = 1'b1; CmdTarget = 8'd200; CmdRate = 8'd5;
        step();
        CmdValid = 1'b0;
        check_outputs("same_target", 1, 8'd200, 1'b0, 1'b1, 1'b1);
        step();
        check_outputs("same_target", 2, 8'd200, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_jump_extremes();
        align();
        CmdValid = 1'b1; CmdTarget = 8'd255; CmdRate = 8'd0;
        for (int c = 1; c <= 5; c++) begin
            step();
            CmdValid = 1'b0;
            check_outputs("jump_up_255", c, (c >= 4) ? 8'd255 : 8'd200, (c <= 3), (c >= 4), (c == 4));
        end
        align();
        CmdValid = 1'b1; CmdTarget = 8'd254; CmdRate = 8'd1;
        for (int c = 1; c <= 5; c++) begin
            step();
            CmdValid = 1'b0;
            check_outputs("step_down_254", c, (c >= 4) ? 8'd254 : 8'd255, (c <= 3), (c >= 4), (c == 4));
        end
    endtask

    task automatic test_reset_mid_ramp();
        apply_reset();
        check_outputs("reset_from_254", 0, 8'd0, 1'b0, 1'b1, 1'b0);
        align();
        CmdValid = 1'b1; CmdTarget = 8'd5; CmdRate = 8'd1;
        for (int c = 1; c <= 9; c++) begin
            step();
            CmdValid = 1'b0;
        end
        check_outputs("mid_ramp_before", 9, 8'd2, 1'b1, 1'b0, 1'b0);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        phase = 0;
        check_outputs("mid_ramp_reset", 10, 8'd0, 1'b0, 1'b1, 1'b0);
        for (int c = 11; c <= 18; c++) begin
            step();
            check_outputs("after_reset", c, 8'd0, 1'b0, 1'b1, 1'b0);
        end
    endtask

`ifdef LED_BREATHE_EN
    task automatic test_breathe();
        logic [7:0] ed;
        align();
        CmdValid = 1'b1; CmdTarget = 8'd2; CmdRate = 8'd1; BreatheReq = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            step();
            CmdValid = 1'b0; BreatheReq = 1'b0;
            case (c / 4)
                0: ed = 8'd0;
                1: ed = 8'd1;
                2: ed = 8'd2;
                3: ed = 8'd1;
                4: ed = 8'd0;
                5: ed = 8'd1;
                default: ed = 8'd2;
            endcase
            check_outputs("breathe", c, ed, 1'b1, 1'b1, 1'b0);
        end
        CmdValid = 1'b1; CmdTarget = 8'd0; CmdRate = 8'd1; BreatheReq = 1'b0;
        for (int c = 27; c <= 33; c++) begin
            step();
            CmdValid = 1'b0;
            ed = (c >= 32) ? 8'd0 : (c >= 28) ? 8'd1 : 8'd2;
            check_outputs("breathe_exit", c, ed, (c <= 31), (c >= 32), (c == 32));
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ramp_up();
        test_ramp_down_holdoff();
        test_same_target();
        test_jump_extremes();
        test_reset_mid_ramp();
`ifdef LED_BREATHE_EN
        test_breathe();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
